// File: rtl/mmio_stream_out.sv
// Memory-mapped byte stream transmitter: core writes bytes into a FIFO drained by a valid/ready sink.
// Optional feature: define MMIO_STREAM_OUT_OVERFLOW_CNT_EN for a dropped-push counter in STATUS[31:16].
module mmio_stream_out #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 16,
  parameter logic [WIDTH-1:0] BASE  = 32'h0000_1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] wdata,
  input  logic             enw,
  output logic [WIDTH-1:0] rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_SENT   = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_sent;

  logic          w_hit;
  logic [1:0]    w_sel;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_sent_wr;
  logic          w_accept;
  logic          w_full;
  logic          w_empty;
  logic [15:0]   w_ovf;
  logic [31:0]   w_status;
  logic [31:0]   w_rd32;

  assign w_hit     = (address[WIDTH-1:4] == BASE[WIDTH-1:4]);
  assign w_sel     = address[3:2];
  assign w_push    = w_hit && enw && (w_sel == SEL_DATA);
  assign w_clear   = w_hit && enw && (w_sel == SEL_CTRL) && wdata[0];
  assign w_sent_wr = w_hit && enw && (w_sel == SEL_SENT);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_pop     = !w_empty && tx_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_accept  = w_push && (!w_full || w_pop);

  assign tx_valid  = !w_empty;
  assign tx_data   = r_mem[r_rptr];

  // FIFO pointers and occupancy; clear overrides any same-cycle push or pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (w_clear) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_accept) r_wptr <= r_wptr + AW'(1);
      if (w_pop)    r_rptr <= r_rptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (w_accept && !w_clear) r_mem[r_wptr] <= wdata[7:0];
  end

  // Popped-byte counter; a pop during a clear still counts, a SENT write wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sent <= 32'h0000_0000;
    end else if (w_sent_wr) begin
      r_sent <= 32'h0000_0000;
    end else if (w_pop) begin
      r_sent <= r_sent + 32'd1;
    end else begin
      r_sent <= r_sent;
    end
  end

`ifdef MMIO_STREAM_OUT_OVERFLOW_CNT_EN
  logic [15:0] r_ovf;
  logic        w_drop;

  assign w_drop = w_push && !w_accept && !w_clear;
  assign w_ovf  = r_ovf;

  // Saturating count of pushes rejected because the FIFO was full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 16'h0000;
    end else if (w_clear) begin
      r_ovf <= 16'h0000;
    end else if (w_drop && (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end else begin
      r_ovf <= r_ovf;
    end
  end
`else
  assign w_ovf = 16'h0000;
`endif

  assign w_status = {w_ovf, 16'h0000} | {15'h0000, 9'(r_count), 6'h00, w_empty, w_full};

  // Register read mux; only STATUS and SENT return data.
  always_comb begin
    w_rd32 = 32'h0000_0000;
    if (w_hit) begin
      case (w_sel)
        SEL_STATUS: w_rd32 = w_status;
        SEL_SENT:   w_rd32 = r_sent;
        default:    w_rd32 = 32'h0000_0000;
      endcase
    end else begin
      w_rd32 = 32'h0000_0000;
    end
  end

  assign rdata = WIDTH'(w_rd32);

endmodule

// File: tb/tb_mmio_stream_out.sv
// Self-checking bench for mmio_stream_out: queue-based model plus directed scenarios.
module tb_mmio_stream_out;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE_L = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        enw = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mq[$];
  logic [31:0] msent = 32'h0;
  logic [15:0] movf = 16'h0;
  logic [7:0]  popped[$];

  mmio_stream_out #(.WIDTH(32), .DEPTH(DEPTH), .BASE(BASE_L)) dut (
    .clock(clock), .reset(reset), .address(address), .wdata(wdata), .enw(enw),
    .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected register read derived from the model state.
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int n;
    n = mq.size();
    if (a[31:4] != BASE_L[31:4]) return 32'h0;
    case (a[3:2])
      2'd1: return 32'(n == DEPTH) + 32'(n == 0) * 2 + 32'(n) * 256 + 32'(movf) * 65536;
      2'd3: return msent;
      default: return 32'h0;
    endcase
  endfunction

  // One clock of bus activity applied to both DUT and model.
  task automatic step();
    logic hit, push, pop, clr, swr, acc;
    logic [1:0] sel;
    hit  = (address[31:4] == BASE_L[31:4]);
    sel  = address[3:2];
    pop  = (mq.size() != 0) && tx_ready;
    push = hit && enw && (sel == 2'd0);
    clr  = hit && enw && (sel == 2'd2) && wdata[0];
    swr  = hit && enw && (sel == 2'd3);
    acc  = push && ((mq.size() < DEPTH) || pop);
    @(posedge clock);
    if (swr) msent = 32'h0;
    else if (pop) msent = msent + 32'd1;
    if (clr) begin
      mq.delete();
      movf = 16'h0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(wdata[7:0]);
`ifdef MMIO_STREAM_OUT_OVERFLOW_CNT_EN
      else if (push && movf != 16'hFFFF) movf = movf + 16'd1;
`endif
    end
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a; wdata = d; enw = 1'b1;
    step();
    enw = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, rdata, exp);
  endtask

  // Per-cycle comparison against the model, and capture of accepted bytes.
  always @(negedge clock) begin
    if (!reset) begin
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, mq.size() != 0});
      if (mq.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, mq[0]});
      chk("rdata", rdata, exp_read(address));
      if (tx_valid && tx_ready) popped.push_back(tx_data);
    end
  end

  initial begin
    #1;
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    rd("rst_status", BASE_L + 32'h4, 32'h0000_0002);
    rd("rst_sent", BASE_L + 32'hC, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

    // Ordering
    wr(BASE_L, 32'h11); wr(BASE_L, 32'h22); wr(BASE_L, 32'h33);
    rd("ord_status", BASE_L + 32'h4, 32'h0000_0300);
    popped.delete();
    tx_ready = 1'b1;
    idle(3);
    tx_ready = 1'b0;
    chk("ord_n", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      chk("ord_b0", {24'h0, popped[0]}, 32'h11);
      chk("ord_b1", {24'h0, popped[1]}, 32'h22);
      chk("ord_b2", {24'h0, popped[2]}, 32'h33);
    end
    rd("ord_sent", BASE_L + 32'hC, 32'd3);

    // Full, 17th byte dropped
    for (int i = 0; i < 17; i++) wr(BASE_L, 32'(8'h40 + i));
`ifdef MMIO_STREAM_OUT_OVERFLOW_CNT_EN
    rd("full_status", BASE_L + 32'h4, 32'h0001_1001);
`else
    rd("full_status", BASE_L + 32'h4, 32'h0000_1001);
`endif
    // Full with simultaneous push and pop
    tx_ready = 1'b1;
    wr(BASE_L, 32'hAA);
    tx_ready = 1'b0;
`ifdef MMIO_STREAM_OUT_OVERFLOW_CNT_EN
    rd("pp_status", BASE_L + 32'h4, 32'h0001_1001);
`else
    rd("pp_status", BASE_L + 32'h4, 32'h0000_1001);
`endif
    popped.delete();
    tx_ready = 1'b1;
    idle(16);
    tx_ready = 1'b0;
    chk("drain_n", popped.size(), 32'd16);
    if (popped.size() == 16) begin
      chk("drain_first", {24'h0, popped[0]}, 32'h41);
      chk("drain_last", {24'h0, popped[15]}, 32'hAA);
    end
    rd("drain_sent", BASE_L + 32'hC, 32'd20);

    // Clear with a pop in the same cycle
    wr(BASE_L, 32'h01); wr(BASE_L, 32'h02); wr(BASE_L, 32'h77);
    tx_ready = 1'b1;
    wr(BASE_L + 32'h8, 32'h1);
    tx_ready = 1'b0;
    chk("clr_valid", {31'h0, tx_valid}, 32'h0);
    rd("clr_status", BASE_L + 32'h4, 32'h0000_0002);
    rd("clr_sent", BASE_L + 32'hC, 32'd21);
    rd("byte_ignore", BASE_L + 32'h5, 32'h0000_0002);

    // Decode miss
    wr(BASE_L + 32'h10, 32'h55);
    rd("dec_rdata", BASE_L + 32'h10, 32'h0);
    chk("dec_valid", {31'h0, tx_valid}, 32'h0);
    rd("dec_status", BASE_L + 32'h4, 32'h0000_0002);

    // SENT clear
    wr(BASE_L + 32'hC, 32'hDEAD_BEEF);
    rd("sent_clr", BASE_L + 32'hC, 32'h0);

    // Reset mid-transfer
    wr(BASE_L, 32'hA1); wr(BASE_L, 32'hA2); wr(BASE_L, 32'hA3);
    rd("pre_rst_status", BASE_L + 32'h4, 32'h0000_0300);
    reset = 1'b1;
    mq.delete(); msent = 32'h0; movf = 16'h0;
    #1;
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    rd("mid_rst_status", BASE_L + 32'h4, 32'h0000_0002);
    rd("mid_rst_sent", BASE_L + 32'hC, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);
    chk("post_rst_valid", {31'h0, tx_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
